// File: rtl/cv32e40x_pkg.sv
// LSU response stage shared types.
// Attribute record carried from issue to response.
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        MPU_OK       = 2'd0,
        MPU_RE_FAULT = 2'd1,
        MPU_WR_FAULT = 2'd2
    } mpu_status_e;

    localparam int LSU_RESP_DEPTH = 2;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [1:0]  offset;
        logic        split;
        mpu_status_e mpu_status;
    } lsu_resp_attr_t;

endpackage

// File: rtl/cv32e40x_lsu_resp_stage_if.sv
// LSU response stage bundle: issue attrs, OBI response,
// write-back side results.
interface cv32e40x_lsu_resp_stage_if;
    import cv32e40x_pkg::*;

    logic        trans_valid_i;
    logic        trans_ready_o;
    logic        trans_we_i;
    logic [1:0]  trans_size_i;
    logic        trans_sext_i;
    logic [1:0]  trans_offset_i;
    logic        trans_split_i;
    mpu_status_e trans_mpu_status_i;

    logic        resp_valid_i;
    logic [31:0] resp_rdata_i;
    logic        resp_err_i;

    logic        lsu_valid_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_err_o;
    mpu_status_e lsu_mpu_status_o;
    logic        lsu_ready_i;
    logic [1:0]  cnt_o;

    modport master (
        output trans_valid_i, trans_we_i, trans_size_i,
        output trans_sext_i, trans_offset_i, trans_split_i,
        output trans_mpu_status_i,
        output resp_valid_i, resp_rdata_i, resp_err_i,
        output lsu_ready_i,
        input  trans_ready_o, lsu_valid_o, lsu_rdata_o,
        input  lsu_err_o, lsu_mpu_status_o, cnt_o
    );

    modport slave (
        input  trans_valid_i, trans_we_i, trans_size_i,
        input  trans_sext_i, trans_offset_i, trans_split_i,
        input  trans_mpu_status_i,
        input  resp_valid_i, resp_rdata_i, resp_err_i,
        input  lsu_ready_i,
        output trans_ready_o, lsu_valid_o, lsu_rdata_o,
        output lsu_err_o, lsu_mpu_status_o, cnt_o
    );

endinterface

// File: rtl/cv32e40x_lsu_rdata_align.sv
// Load data extract / split merge / extend.
// Purely combinational.
module cv32e40x_lsu_rdata_align
    import cv32e40x_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_size,
    input  logic        i_sext,
    input  logic [1:0]  i_offset,
    input  logic        i_second,
    input  logic [31:0] i_held,
    input  logic [1:0]  i_off_first,
    output logic [31:0] o_shifted,
    output logic [31:0] o_rdata
);

    logic [5:0]  w_up_sh;
    logic [31:0] w_merged;
    logic [31:0] w_src;

    assign o_shifted = i_rdata >> {i_offset, 3'b000};

    // Second beat bytes land above the bytes kept from beat one.
    assign w_up_sh  = 6'd32 - {1'b0, i_off_first, 3'b000};
    assign w_merged = i_held | (i_rdata << w_up_sh);
    assign w_src    = i_second ? w_merged : o_shifted;

    // Select the access width and extend to 32 bits.
    always_comb begin
        o_rdata = w_src;
        case (i_size)
            SIZE_BYTE: o_rdata = {{24{i_sext & w_src[7]}},
                                  w_src[7:0]};
            SIZE_HALF: o_rdata = {{16{i_sext & w_src[15]}},
                                  w_src[15:0]};
            default:   o_rdata = w_src;
        endcase
    end

endmodule

// File: rtl/cv32e40x_lsu_resp_stage.sv
// LSU response stage: in-order attribute FIFO, response
// pairing, split-access merge. DEPTH must be 1..3 (cnt_o 2b).
module cv32e40x_lsu_resp_stage
    import cv32e40x_pkg::*;
#(
    parameter int DEPTH = LSU_RESP_DEPTH
)
(
    input logic                      clk,
    input logic                      rst_n,
    cv32e40x_lsu_resp_stage_if.slave bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0]    DEPTH_C = 2'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    lsu_resp_attr_t r_fifo [DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [1:0]     r_cnt;
    logic [31:0]    r_hold;
    logic           r_err_first_q;
    logic [1:0]     r_off_first;
    logic           r_second;

    lsu_resp_attr_t w_head;
    lsu_resp_attr_t w_new;
    logic           w_nonempty;
    logic           w_head_ok;
    logic           w_ready;
    logic           w_push;
    logic           w_pop;
    logic [31:0]    w_shifted;
    logic [31:0]    w_aligned;

    function automatic logic [PW-1:0] f_inc(
        input logic [PW-1:0] p
    );
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    assign w_new = '{
        we:         bus.trans_we_i,
        size:       bus.trans_size_i,
        sext:       bus.trans_sext_i,
        offset:     bus.trans_offset_i,
        split:      bus.trans_split_i,
        mpu_status: bus.trans_mpu_status_i
    };

    assign w_head     = r_fifo[r_rptr];
    assign w_nonempty = (r_cnt != 2'd0);
    assign w_head_ok  = (w_head.mpu_status == MPU_OK);
    assign w_ready    = (r_cnt < DEPTH_C);
    assign w_push     = bus.trans_valid_i & w_ready;
    // Blocked heads never see a bus beat, so they retire alone.
    assign w_pop      = w_nonempty &
                        (w_head_ok ? bus.resp_valid_i : 1'b1);

    cv32e40x_lsu_rdata_align u_align (
        .i_rdata     (bus.resp_rdata_i),
        .i_size      (w_head.size),
        .i_sext      (w_head.sext),
        .i_offset    (w_head.offset),
        .i_second    (r_second),
        .i_held      (r_hold),
        .i_off_first (r_off_first),
        .o_shifted   (w_shifted),
        .o_rdata     (w_aligned)
    );

    assign bus.trans_ready_o    = w_ready;
    assign bus.cnt_o            = r_cnt;
    assign bus.lsu_valid_o      = w_pop;
    assign bus.lsu_mpu_status_o = w_nonempty ? w_head.mpu_status
                                             : MPU_OK;
    assign bus.lsu_err_o = w_pop &
                           ((w_head_ok & bus.resp_err_i) |
                            (r_second & r_err_first_q));
    assign bus.lsu_rdata_o = (w_pop & w_head_ok & ~w_head.we)
                             ? w_aligned : 32'd0;

    // FIFO storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_new;
                r_wptr         <= f_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Split-access state: bytes and error of the first beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold        <= 32'd0;
            r_err_first_q <= 1'b0;
            r_off_first   <= 2'd0;
            r_second      <= 1'b0;
        end else if (w_pop) begin
            if (r_second) begin
                r_second      <= 1'b0;
                r_err_first_q <= 1'b0;
            end else if (w_head.split) begin
                r_second      <= 1'b1;
                r_hold        <= w_shifted;
                r_off_first   <= w_head.offset;
                r_err_first_q <= w_head_ok & bus.resp_err_i;
            end
        end
    end

    a_no_backpressure : assert property (
        @(posedge clk) disable iff (!rst_n)
        bus.lsu_valid_o |-> bus.lsu_ready_i
    );

    a_resp_protocol : assert property (
        @(posedge clk) disable iff (!rst_n)
        bus.resp_valid_i |-> (w_nonempty && w_head_ok)
    );

endmodule

// File: tb/tb_cv32e40x_lsu_resp_stage.sv
// Directed bench for the LSU response stage with a
// scoreboard of expected write-back results.
module tb_cv32e40x_lsu_resp_stage;
    import cv32e40x_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    exp_t sb_q [$];

    cv32e40x_lsu_resp_stage_if bus ();

    cv32e40x_lsu_resp_stage #(.DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h",
                    tag, obs, exp);
    endtask

    function automatic logic [31:0] ld_model(
        input logic [31:0] d, input logic [1:0] sz,
        input logic sx, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*off +: 8];
        h = (off == 2'd3) ? 16'h0 : d[8*off +: 16];
        if (sz == 2'd0) return {{24{sx & b[7]}}, b};
        if (sz == 2'd1) return {{16{sx & h[15]}}, h};
        return d;
    endfunction

    task automatic sb_exp(input logic [31:0] d, input logic e,
                          input logic cd);
        exp_t x;
        x.rdata = d; x.err = e; x.chk_data = cd;
        sb_q.push_back(x);
    endtask

    task automatic sb_check(input string tag);
        exp_t x;
        chk({tag, "_valid"}, 32'(bus.lsu_valid_o), 32'd1);
        if (sb_q.size() == 0) begin
            n_total++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            x = sb_q.pop_front();
            if (x.chk_data)
                chk({tag, "_rdata"}, bus.lsu_rdata_o, x.rdata);
            chk({tag, "_err"}, 32'(bus.lsu_err_o), 32'(x.err));
        end
    endtask

    task automatic drive_trans(input logic we, input logic [1:0] sz,
                               input logic sx, input logic [1:0] off,
                               input logic sp, input mpu_status_e m);
        bus.trans_valid_i      = 1'b1;
        bus.trans_we_i         = we;
        bus.trans_size_i       = sz;
        bus.trans_sext_i       = sx;
        bus.trans_offset_i     = off;
        bus.trans_split_i      = sp;
        bus.trans_mpu_status_i = m;
    endtask

    task automatic do_push(input logic we, input logic [1:0] sz,
                           input logic sx, input logic [1:0] off,
                           input logic sp, input mpu_status_e m);
        @(negedge clk);
        drive_trans(we, sz, sx, off, sp, m);
        @(posedge clk);
        #1;
        bus.trans_valid_i = 1'b0;
    endtask

    task automatic do_resp(input string tag, input logic [31:0] d,
                           input logic e);
        @(negedge clk);
        bus.resp_valid_i = 1'b1;
        bus.resp_rdata_i = d;
        bus.resp_err_i   = e;
        #1;
        sb_check(tag);
        @(posedge clk);
        #1;
        bus.resp_valid_i = 1'b0;
        bus.resp_err_i   = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cnt"}, 32'(bus.cnt_o), 32'd0);
        chk({tag, "_ready"}, 32'(bus.trans_ready_o), 32'd1);
        chk({tag, "_valid"}, 32'(bus.lsu_valid_o), 32'd0);
        chk({tag, "_err"}, 32'(bus.lsu_err_o), 32'd0);
        chk({tag, "_rdata"}, bus.lsu_rdata_o, 32'd0);
        chk({tag, "_mpu"}, 32'(bus.lsu_mpu_status_o),
            32'(MPU_OK));
        chk({tag, "_errq"}, 32'(dut.r_err_first_q), 32'd0);
        chk({tag, "_hold"}, dut.r_hold, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  sz;
        logic [1:0]  off;
        logic        sx;
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        bus.trans_valid_i      = 1'b0;
        bus.trans_we_i         = 1'b0;
        bus.trans_size_i       = 2'd0;
        bus.trans_sext_i       = 1'b0;
        bus.trans_offset_i     = 2'd0;
        bus.trans_split_i      = 1'b0;
        bus.trans_mpu_status_i = MPU_OK;
        bus.resp_valid_i       = 1'b0;
        bus.resp_rdata_i       = 32'd0;
        bus.resp_err_i         = 1'b0;
        bus.lsu_ready_i        = 1'b1;

        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;

        // lbu / lb at offset 3
        do_push(1'b0, 2'd0, 1'b0, 2'd3, 1'b0, MPU_OK);
        sb_exp(32'h0000_0080, 1'b0, 1'b1);
        chk("lbu_cnt", 32'(bus.cnt_o), 32'd1);
        chk("lbu_wait", 32'(bus.lsu_valid_o), 32'd0);
        do_resp("lbu", 32'h8012_3456, 1'b0);
        do_push(1'b0, 2'd0, 1'b1, 2'd3, 1'b0, MPU_OK);
        sb_exp(32'hFFFF_FF80, 1'b0, 1'b1);
        do_resp("lb", 32'h8012_3456, 1'b0);
        chk("lb_cnt", 32'(bus.cnt_o), 32'd0);

        // split lw at offset 2
        do_push(1'b0, 2'd2, 1'b0, 2'd2, 1'b1, MPU_OK);
        sb_exp(32'h0, 1'b0, 1'b0);
        do_push(1'b0, 2'd2, 1'b0, 2'd0, 1'b0, MPU_OK);
        sb_exp(32'h3344_AABB, 1'b0, 1'b1);
        chk("full_cnt", 32'(bus.cnt_o), 32'd2);
        chk("full_ready", 32'(bus.trans_ready_o), 32'd0);
        do_resp("splw1", 32'hAABB_CCDD, 1'b0);
        do_resp("splw2", 32'h1122_3344, 1'b0);

        // split lh at offset 3, error on first beat only
        do_push(1'b0, 2'd1, 1'b1, 2'd3, 1'b1, MPU_OK);
        sb_exp(32'h0, 1'b1, 1'b0);
        do_push(1'b0, 2'd1, 1'b1, 2'd0, 1'b0, MPU_OK);
        sb_exp(32'hFFFF_C3A5, 1'b1, 1'b1);
        do_resp("sperr1", 32'hA500_0000, 1'b1);
        do_resp("sperr2", 32'h0000_00C3, 1'b0);
        chk("sperr_clr", 32'(dut.r_err_first_q), 32'd0);
        do_push(1'b0, 2'd2, 1'b0, 2'd0, 1'b0, MPU_OK);
        sb_exp(32'h1357_9BDF, 1'b0, 1'b1);
        do_resp("after_err", 32'h1357_9BDF, 1'b0);

        // MPU-blocked load retires without a bus beat
        do_push(1'b0, 2'd2, 1'b0, 2'd0, 1'b0, MPU_RE_FAULT);
        sb_exp(32'h0, 1'b0, 1'b1);
        chk("mpu_cnt1", 32'(bus.cnt_o), 32'd1);
        chk("mpu_stat", 32'(bus.lsu_mpu_status_o),
            32'(MPU_RE_FAULT));
        sb_check("mpu");
        @(posedge clk);
        #1;
        chk("mpu_cnt0", 32'(bus.cnt_o), 32'd0);
        chk("mpu_idle", 32'(bus.lsu_mpu_status_o), 32'(MPU_OK));

        // full FIFO refuses push in a pop cycle
        do_push(1'b0, 2'd2, 1'b0, 2'd0, 1'b0, MPU_OK);
        sb_exp(32'h0102_0304, 1'b0, 1'b1);
        do_push(1'b0, 2'd2, 1'b0, 2'd0, 1'b0, MPU_OK);
        sb_exp(32'h0506_0708, 1'b0, 1'b1);
        @(negedge clk);
        bus.resp_valid_i = 1'b1;
        bus.resp_rdata_i = 32'h0102_0304;
        drive_trans(1'b0, 2'd2, 1'b0, 2'd0, 1'b0, MPU_OK);
        #1;
        chk("refuse_ready", 32'(bus.trans_ready_o), 32'd0);
        sb_check("popA");
        @(posedge clk);
        #1;
        chk("refuse_cnt", 32'(bus.cnt_o), 32'd1);
        @(negedge clk);
        bus.resp_rdata_i = 32'h0506_0708;
        #1;
        chk("pp_ready", 32'(bus.trans_ready_o), 32'd1);
        sb_check("popB");
        sb_exp(32'h0A0B_0C0D, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        bus.trans_valid_i = 1'b0;
        bus.resp_valid_i  = 1'b0;
        chk("pp_cnt", 32'(bus.cnt_o), 32'd1);
        do_resp("popC", 32'h0A0B_0C0D, 1'b0);

        // assorted narrow loads against the model
        for (int i = 0; i < 8; i++) begin
            sz  = 2'($urandom_range(0, 1));
            off = (sz == 2'd1) ? 2'($urandom_range(0, 2))
                               : 2'($urandom_range(0, 3));
            sx  = 1'($urandom_range(0, 1));
            d   = $urandom;
            do_push(1'b0, sz, sx, off, 1'b0, MPU_OK);
            sb_exp(ld_model(d, sz, sx, off), 1'b0, 1'b1);
            do_resp($sformatf("rnd%0d", i), d, 1'b0);
        end

        // store returns zero data
        do_push(1'b1, 2'd2, 1'b0, 2'd0, 1'b0, MPU_OK);
        sb_exp(32'h0, 1'b0, 1'b1);
        do_resp("store", 32'hDEAD_BEEF, 1'b0);

        // reset while two entries are outstanding
        do_push(1'b0, 2'd2, 1'b0, 2'd0, 1'b0, MPU_OK);
        do_push(1'b0, 2'd2, 1'b0, 2'd0, 1'b0, MPU_OK);
        chk("pre_rst_cnt", 32'(bus.cnt_o), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_push(1'b0, 2'd2, 1'b0, 2'd0, 1'b0, MPU_OK);
        sb_exp(32'hCAFE_F00D, 1'b0, 1'b1);
        chk("post_rst_cnt", 32'(bus.cnt_o), 32'd1);
        do_resp("post_rst", 32'hCAFE_F00D, 1'b0);
        chk("end_cnt", 32'(bus.cnt_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
